// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences each instruction through IF/ID/EXE/MEM/WB,
// drives the fetch handshake (PCWre/PCSrc/IRWre) and the datapath selects.
// Optional build macro: ILLEGAL_OP_TRAP_EN -- when defined, an unlisted opcode
// in ID halts the machine with illegal=1; otherwise it is executed as a NOP.
module multicycle_ctrl #(
  parameter int OPW = 6,
  parameter int STW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           sign,
  output logic           PCWre,
  output logic [1:0]     PCSrc,
  output logic           IRWre,
  output logic           ALUSrcA,
  output logic           ALUSrcB,
  output logic [2:0]     ALUOp,
  output logic           ExtSel,
  output logic           RegWre,
  output logic [1:0]     RegDst,
  output logic [1:0]     WrRegDSrc,
  output logic           mRD,
  output logic           mWR,
  output logic [STW-1:0] state,
  output logic           illegal
);

  typedef enum logic [STW-1:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,  // also the halt state, qualified by halted_q
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_L   = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_e;

  localparam logic [OPW-1:0] OP_ADD   = 6'b000000;
  localparam logic [OPW-1:0] OP_SUB   = 6'b000001;
  localparam logic [OPW-1:0] OP_ADDIU = 6'b000010;
  localparam logic [OPW-1:0] OP_AND   = 6'b010000;
  localparam logic [OPW-1:0] OP_ANDI  = 6'b010001;
  localparam logic [OPW-1:0] OP_ORI   = 6'b010010;
  localparam logic [OPW-1:0] OP_XORI  = 6'b010011;
  localparam logic [OPW-1:0] OP_OR    = 6'b010100;
  localparam logic [OPW-1:0] OP_SLL   = 6'b011000;
  localparam logic [OPW-1:0] OP_SLTI  = 6'b100110;
  localparam logic [OPW-1:0] OP_SLT   = 6'b100111;
  localparam logic [OPW-1:0] OP_SW    = 6'b110000;
  localparam logic [OPW-1:0] OP_LW    = 6'b110001;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b110100;
  localparam logic [OPW-1:0] OP_BNE   = 6'b110101;
  localparam logic [OPW-1:0] OP_BLTZ  = 6'b110110;
  localparam logic [OPW-1:0] OP_J     = 6'b111000;
  localparam logic [OPW-1:0] OP_JR    = 6'b111001;
  localparam logic [OPW-1:0] OP_JAL   = 6'b111010;
  localparam logic [OPW-1:0] OP_HALT  = 6'b111111;

  state_e state_q, state_d;
  logic   halted_q, halted_d;
`ifdef ILLEGAL_OP_TRAP_EN
  logic   illegal_q, illegal_d;
`endif

  // State, halt and trap registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IF;
      halted_q  <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge values, independent of block ordering.
      state_q   <= state_d;
      halted_q  <= halted_d;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Next-state and output decode; everything is forced to 0 while rst is low.
  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no
    // path through the case statements can leave one unassigned (no latches).
    state_d   = state_q;
    halted_d  = halted_q;
`ifdef ILLEGAL_OP_TRAP_EN
    illegal_d = illegal_q;
`endif
    PCWre     = 1'b0;
    PCSrc     = 2'b00;
    IRWre     = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = 3'b000;
    ExtSel    = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 2'b00;
    mRD       = 1'b0;
    mWR       = 1'b0;

    if (rst && !halted_q) begin
      unique case (state_q)
        S_IF: begin
          IRWre   = 1'b1;
          state_d = S_ID;
        end

        S_ID: begin
          case (opcode)
            OP_J: begin
              PCSrc   = 2'b11;
              PCWre   = 1'b1;
              state_d = S_IF;
            end
            OP_JAL: begin
              PCSrc     = 2'b11;
              RegDst    = 2'b00;
              WrRegDSrc = 2'b10;
              RegWre    = 1'b1;
              PCWre     = 1'b1;
              state_d   = S_IF;
            end
            OP_JR: begin
              PCSrc   = 2'b10;
              PCWre   = 1'b1;
              state_d = S_IF;
            end
            OP_HALT:                 halted_d = 1'b1;
            OP_BEQ, OP_BNE, OP_BLTZ: state_d  = S_EXE_BR;
            OP_SW, OP_LW:            state_d  = S_EXE_LS;
            OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_XORI,
            OP_OR, OP_SLL, OP_SLTI, OP_SLT:
                                     state_d  = S_EXE_AL;
            default: begin
`ifdef ILLEGAL_OP_TRAP_EN
              halted_d  = 1'b1;
              illegal_d = 1'b1;
`else
              PCWre   = 1'b1;
              state_d = S_IF;
`endif
            end
          endcase
        end

        S_EXE_AL: begin
          case (opcode)
            OP_SUB:   ALUOp = 3'b001;
            OP_ADDIU: begin ALUSrcB = 1'b1; ExtSel = 1'b1; end
            OP_AND:   ALUOp = 3'b100;
            OP_ANDI:  begin ALUOp = 3'b100; ALUSrcB = 1'b1; end
            OP_ORI:   begin ALUOp = 3'b011; ALUSrcB = 1'b1; end
            OP_XORI:  begin ALUOp = 3'b111; ALUSrcB = 1'b1; end
            OP_OR:    ALUOp = 3'b011;
            OP_SLL:   begin ALUOp = 3'b010; ALUSrcA = 1'b1; end
            OP_SLTI:  begin ALUOp = 3'b110; ALUSrcB = 1'b1; ExtSel = 1'b1; end
            OP_SLT:   ALUOp = 3'b110;
            default:  ALUOp = 3'b000;  // add
          endcase
          state_d = S_WB_AL;
        end

        S_WB_AL: begin
          RegWre = 1'b1;
          case (opcode)
            OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: RegDst = 2'b01;
            default:                                     RegDst = 2'b10;
          endcase
          PCWre   = 1'b1;
          state_d = S_IF;
        end

        S_EXE_BR: begin
          ALUOp  = 3'b001;
          ExtSel = 1'b1;
          PCWre  = 1'b1;
          case (opcode)
            OP_BEQ:  PCSrc = zero  ? 2'b01 : 2'b00;
            OP_BNE:  PCSrc = !zero ? 2'b01 : 2'b00;
            OP_BLTZ: PCSrc = sign  ? 2'b01 : 2'b00;
            default: PCSrc = 2'b00;
          endcase
          state_d = S_IF;
        end

        S_EXE_LS: begin
          ALUSrcB = 1'b1;
          ExtSel  = 1'b1;
          state_d = S_MEM;
        end

        S_MEM: begin
          if (opcode == OP_LW) begin
            mRD     = 1'b1;
            state_d = S_WB_L;
          end else begin
            mWR     = 1'b1;
            PCWre   = 1'b1;
            state_d = S_IF;
          end
        end

        S_WB_L: begin
          mRD       = 1'b1;
          RegWre    = 1'b1;
          WrRegDSrc = 2'b01;
          RegDst    = 2'b01;
          PCWre     = 1'b1;
          state_d   = S_IF;
        end

        default: state_d = S_IF;
      endcase
    end
  end

  // Debug state and trap flag, both masked while reset is held.
  always_comb begin
    state = rst ? state_q : S_IF;
`ifdef ILLEGAL_OP_TRAP_EN
    illegal = rst & illegal_q;
`else
    illegal = 1'b0;
`endif
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus thread queues the
// expected per-cycle output vector, a monitor thread pops and compares it on
// every falling clock edge while the queue holds entries.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwre;
    logic [1:0] pcsrc;
    logic       irwre;
    logic       asa;
    logic       asb;
    logic [2:0] aluop;
    logic       ext;
    logic       regwre;
    logic [1:0] regdst;
    logic [1:0] wrsrc;
    logic       mrd;
    logic       mwr;
    logic       ill;
  } out_t;

  typedef struct {
    string name;
    out_t  v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       sign = 1'b0;
  logic       PCWre, IRWre, ALUSrcA, ALUSrcB, ExtSel, RegWre, mRD, mWR, illegal;
  logic [1:0] PCSrc, RegDst, WrRegDSrc;
  logic [2:0] ALUOp, state;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .sign(sign),
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel), .RegWre(RegWre),
    .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .mRD(mRD), .mWR(mWR),
    .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Monitor: one comparison per falling edge while expectations are pending.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      out_t a;
      e = sb.pop_front();
      a = '{st: state, pcwre: PCWre, pcsrc: PCSrc, irwre: IRWre, asa: ALUSrcA,
            asb: ALUSrcB, aluop: ALUOp, ext: ExtSel, regwre: RegWre,
            regdst: RegDst, wrsrc: WrRegDSrc, mrd: mRD, mwr: mWR, ill: illegal};
      n_tests++;
      if (a !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b (st pcwre pcsrc irwre asa asb aluop ext regwre regdst wrsrc mrd mwr ill)",
                 e.name, a, e.v);
      end
    end
  end

  function automatic out_t mk(input logic [2:0] st, input logic pcwre,
                              input logic [1:0] pcsrc, input logic irwre,
                              input logic asa, input logic asb,
                              input logic [2:0] aluop, input logic ext,
                              input logic regwre, input logic [1:0] regdst,
                              input logic [1:0] wrsrc, input logic mrd,
                              input logic mwr, input logic ill);
    return '{st, pcwre, pcsrc, irwre, asa, asb, aluop, ext, regwre, regdst,
             wrsrc, mrd, mwr, ill};
  endfunction

  function automatic out_t v_if();
    return mk(3'b000, 0, 2'b00, 1, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0, 0);
  endfunction

  function automatic out_t v_st(input logic [2:0] st, input logic ill);
    return mk(st, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0, ill);
  endfunction

  task automatic push(input string name, input out_t v);
    exp_t e;
    e.name = name;
    e.v    = v;
    sb.push_back(e);
  endtask

  // Advance n cycles, ending 1 time unit after a rising edge.
  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset for n cycles (all outputs 0), then release into sIF.
  task automatic reset_seq(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) push("reset", v_st(3'b000, 0));
    go(n);
    rst = 1'b1;
  endtask

  task automatic alu_instr(input string name, input logic [5:0] op,
                           input logic [2:0] aluop, input logic asa,
                           input logic asb, input logic ext,
                           input logic [1:0] regdst);
    opcode = op;
    push({name, ".if"},  v_if());
    push({name, ".id"},  v_st(3'b001, 0));
    push({name, ".exe"}, mk(3'b110, 0, 2'b00, 0, asa, asb, aluop, ext, 0, 2'b00, 2'b00, 0, 0, 0));
    push({name, ".wb"},  mk(3'b111, 1, 2'b00, 0, 0, 0, 3'b000, 0, 1, regdst, 2'b00, 0, 0, 0));
    go(4);
  endtask

  task automatic br_instr(input string name, input logic [5:0] op,
                          input logic z, input logic s, input logic [1:0] pcsrc);
    opcode = op;
    zero   = z;
    sign   = s;
    push({name, ".if"},  v_if());
    push({name, ".id"},  v_st(3'b001, 0));
    push({name, ".exe"}, mk(3'b101, 1, pcsrc, 0, 0, 0, 3'b001, 1, 0, 2'b00, 2'b00, 0, 0, 0));
    go(3);
  endtask

  task automatic jmp_instr(input string name, input logic [5:0] op,
                           input out_t id_v);
    opcode = op;
    push({name, ".if"}, v_if());
    push({name, ".id"}, id_v);
    go(2);
  endtask

  initial begin
    @(posedge clk);
    #1;
    opcode = 6'b000000;
    reset_seq(3);

    // ALU group: opcode, ALUOp, SrcA, SrcB, ExtSel, RegDst
    alu_instr("add",   6'b000000, 3'b000, 0, 0, 0, 2'b10);
    alu_instr("sub",   6'b000001, 3'b001, 0, 0, 0, 2'b10);
    alu_instr("addiu", 6'b000010, 3'b000, 0, 1, 1, 2'b01);
    alu_instr("and",   6'b010000, 3'b100, 0, 0, 0, 2'b10);
    alu_instr("andi",  6'b010001, 3'b100, 0, 1, 0, 2'b01);
    alu_instr("ori",   6'b010010, 3'b011, 0, 1, 0, 2'b01);
    alu_instr("xori",  6'b010011, 3'b111, 0, 1, 0, 2'b01);
    alu_instr("or",    6'b010100, 3'b011, 0, 0, 0, 2'b10);
    alu_instr("sll",   6'b011000, 3'b010, 1, 0, 0, 2'b10);
    alu_instr("slti",  6'b100110, 3'b110, 0, 1, 1, 2'b01);
    alu_instr("slt",   6'b100111, 3'b110, 0, 0, 0, 2'b10);

    // lw: 5 cycles, mRD in MEM and WB_L, RegWre only in WB_L
    opcode = 6'b110001;
    push("lw.if",  v_if());
    push("lw.id",  v_st(3'b001, 0));
    push("lw.exe", mk(3'b010, 0, 2'b00, 0, 0, 1, 3'b000, 1, 0, 2'b00, 2'b00, 0, 0, 0));
    push("lw.mem", mk(3'b011, 0, 2'b00, 0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 1, 0, 0));
    push("lw.wb",  mk(3'b100, 1, 2'b00, 0, 0, 0, 3'b000, 0, 1, 2'b01, 2'b01, 1, 0, 0));
    go(5);

    // sw: 4 cycles, mWR and PCWre in MEM
    opcode = 6'b110000;
    push("sw.if",  v_if());
    push("sw.id",  v_st(3'b001, 0));
    push("sw.exe", mk(3'b010, 0, 2'b00, 0, 0, 1, 3'b000, 1, 0, 2'b00, 2'b00, 0, 0, 0));
    push("sw.mem", mk(3'b011, 1, 2'b00, 0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 1, 0));
    go(4);

    // Branches: taken/not-taken for each condition
    br_instr("beq_z1",  6'b110100, 1, 0, 2'b01);
    br_instr("beq_z0",  6'b110100, 0, 0, 2'b00);
    br_instr("bne_z0",  6'b110101, 0, 1, 2'b01);
    br_instr("bne_z1",  6'b110101, 1, 0, 2'b00);
    br_instr("bltz_s1", 6'b110110, 0, 1, 2'b01);
    br_instr("bltz_s0", 6'b110110, 1, 0, 2'b00);
    zero = 1'b0;
    sign = 1'b0;

    // Jumps resolve in ID
    jmp_instr("j",   6'b111000, mk(3'b001, 1, 2'b11, 0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    jmp_instr("jr",  6'b111001, mk(3'b001, 1, 2'b10, 0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    jmp_instr("jal", 6'b111010, mk(3'b001, 1, 2'b11, 0, 0, 0, 3'b000, 0, 1, 2'b00, 2'b10, 0, 0, 0));

    // Unlisted opcode 101010
    opcode = 6'b101010;
    push("unl.if", v_if());
`ifdef ILLEGAL_OP_TRAP_EN
    push("unl.id", v_st(3'b001, 0));
    for (int i = 0; i < 6; i++) push("unl.trap", v_st(3'b001, 1));
    go(8);
    reset_seq(2);
`else
    push("unl.nop", mk(3'b001, 1, 2'b00, 0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    go(2);
`endif

    // halt: PCWre stays 0 for 20 cycles, state held at 001
    opcode = 6'b111111;
    push("halt.if", v_if());
    push("halt.id", v_st(3'b001, 0));
    for (int i = 0; i < 20; i++) push("halt.hold", v_st(3'b001, 0));
    go(22);
    reset_seq(2);

    // add aborted by reset in EXE_AL: no RegWre, state back to 000
    opcode = 6'b000000;
    push("abort.if", v_if());
    push("abort.id", v_st(3'b001, 0));
    go(2);
    reset_seq(3);

    // First instruction after reset runs normally
    alu_instr("post_rst_add", 6'b000000, 3'b000, 0, 0, 0, 2'b10);

    // Every queued expectation must have been consumed
    go(3);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
